// File: rtl/fir_axil_slave.sv
// AXI-Lite responder for the FIR configuration space: ap_ctrl, data_length,
// tap BRAM forwarding, ap_start pulse generation and engine done/idle tracking.
module fir_axil_slave #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int NUM_TAPS = 11
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic              ap_start_o,
    input  logic              engine_done_i,
    output logic [DATA_W-1:0] data_length_o,
    output logic              tap_EN,
    output logic [3:0]        tap_WE,
    output logic [ADDR_W-1:0] tap_A,
    output logic [DATA_W-1:0] tap_Di,
    input  logic [DATA_W-1:0] tap_Do
);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(32'h000);
    localparam logic [ADDR_W-1:0] ADDR_LEN  = ADDR_W'(32'h010);
    localparam logic [ADDR_W-1:0] TAP_BASE  = ADDR_W'(32'h080);
    localparam logic [ADDR_W-1:0] TAP_END   = ADDR_W'(32'h080 + 4 * NUM_TAPS);

    typedef enum logic {W_IDLE, W_GAP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

    w_state_t          w_state_reg;
    r_state_t          r_state_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              tap_fetch_reg;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              ap_start_reg;
    logic              ap_done_reg;
    logic              ap_idle_reg;
    logic [DATA_W-1:0] data_length_reg;

    logic              wr_req;
    logic              wr_accept;
    logic              rd_accept;
    logic              tap_wr;
    logic              tap_rd;
    logic [DATA_W-1:0] ctrl_word;

    function automatic logic is_tap(input logic [ADDR_W-1:0] addr);
        return (addr >= TAP_BASE) && (addr < TAP_END) && (addr[1:0] == 2'b00);
    endfunction

    // Writes win over reads; both need both FSMs idle so a held Wishbone
    // request is accepted exactly once.
    assign wr_req    = awvalid & wvalid;
    assign wr_accept = wr_req & (w_state_reg == W_IDLE) & (r_state_reg == R_IDLE) & ~wb_rst_i;
    assign rd_accept = arvalid & ~wr_req & (w_state_reg == W_IDLE) & (r_state_reg == R_IDLE)
                       & ~wb_rst_i;

    assign awready = wr_accept;
    assign wready  = wr_accept;
    assign arready = rd_accept;

    // The BRAM belongs to the engine while it runs.
    assign tap_wr = wr_accept & is_tap(awaddr) & ap_idle_reg;
    assign tap_rd = rd_accept & is_tap(araddr) & ap_idle_reg;

    always_comb begin
        tap_EN = tap_wr | tap_rd;
        tap_WE = tap_wr ? 4'hF : 4'h0;
        tap_Di = tap_wr ? wdata : '0;
        tap_A  = '0;
        if (tap_wr)
            tap_A = awaddr - TAP_BASE;
        else if (tap_rd)
            tap_A = araddr - TAP_BASE;
    end

    assign ctrl_word     = {{(DATA_W-3){1'b0}}, ap_idle_reg, ap_done_reg, ap_start_reg};
    assign rvalid        = rvalid_reg;
    assign rdata         = rdata_reg;
    assign ap_start_o    = ap_start_reg;
    assign data_length_o = data_length_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            w_state_reg     <= W_IDLE;
            r_state_reg     <= R_IDLE;
            rd_addr_reg     <= '0;
            tap_fetch_reg   <= 1'b0;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= '0;
            ap_start_reg    <= 1'b0;
            ap_done_reg     <= 1'b0;
            ap_idle_reg     <= 1'b1;
            data_length_reg <= '0;
        end else begin
            ap_start_reg <= 1'b0;
            w_state_reg  <= (w_state_reg == W_IDLE && wr_accept) ? W_GAP : W_IDLE;

            if (engine_done_i) begin
                ap_done_reg <= 1'b1;
                ap_idle_reg <= 1'b1;
            end

            if (wr_accept) begin
                if (awaddr == ADDR_LEN)
                    data_length_reg <= wdata;
                if (awaddr == ADDR_CTRL && wdata[0] && ap_idle_reg) begin
                    ap_start_reg <= 1'b1;
                    ap_idle_reg  <= 1'b0;
                    ap_done_reg  <= 1'b0;
                end
            end

            case (r_state_reg)
                R_IDLE: begin
                    if (rd_accept) begin
                        rd_addr_reg   <= araddr;
                        tap_fetch_reg <= tap_rd;
                        r_state_reg   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    if (rd_addr_reg == ADDR_CTRL) begin
                        rdata_reg <= ctrl_word;
                        // A done pulse landing in the same cycle must not be lost.
                        if (!engine_done_i)
                            ap_done_reg <= 1'b0;
                    end else if (rd_addr_reg == ADDR_LEN) begin
                        rdata_reg <= data_length_reg;
                    end else if (tap_fetch_reg) begin
                        rdata_reg <= tap_Do;
                    end else begin
                        rdata_reg <= '0;
                    end
                    rvalid_reg  <= 1'b1;
                    r_state_reg <= R_RESP;
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_axil_slave.sv
// Directed + randomized bench for fir_axil_slave with a behavioural register
// model and a tap BRAM model.
module tb_fir_axil_slave;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int NUM_TAPS = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0] awaddr, araddr, tap_A;
    logic [DATA_W-1:0] wdata, rdata, data_length_o, tap_Di, tap_Do;
    logic              ap_start_o, engine_done_i, tap_EN;
    logic [3:0]        tap_WE;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_axil_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ap_start_o(ap_start_o), .engine_done_i(engine_done_i), .data_length_o(data_length_o),
        .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do)
    );

    // Single-port tap BRAM with registered read
    logic [DATA_W-1:0] tap_mem [0:1023];
    int tap_en_count = 0;
    always @(posedge clk) begin
        if (tap_EN) begin
            tap_en_count <= tap_en_count + 1;
            if (tap_WE == 4'hF)
                tap_mem[tap_A[11:2]] <= tap_Di;
            tap_Do <= tap_mem[tap_A[11:2]];
        end
    end

    // Reference model of the register file
    logic [31:0] m_taps [NUM_TAPS];
    logic [31:0] m_len;
    bit          m_done, m_idle;

    function automatic int tap_index(input logic [11:0] a);
        int ai;
        ai = int'(a);
        if (ai >= 128 && ai < 128 + 4 * NUM_TAPS && ai % 4 == 0)
            return (ai - 128) / 4;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_len  = 0;
        m_done = 0;
        m_idle = 1;
    endtask

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int idx, n, cnt0;
        bit exp_tap, exp_start;
        idx       = tap_index(a);
        exp_tap   = (idx >= 0) && m_idle;
        exp_start = (a == 12'h000) && d[0] && m_idle;
        @(negedge clk);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = d;
        #1;
        n = 0;
        while (!awready && n < 8) begin
            @(negedge clk); #1; n++;
        end
        check("wr_accept", {31'b0, awready & wready}, 32'd1);
        check("wr_tap_en", {31'b0, tap_EN}, {31'b0, exp_tap});
        if (exp_tap) begin
            check("wr_tap_we", {28'b0, tap_WE}, 32'hF);
            check("wr_tap_a", {20'b0, tap_A}, {20'b0, a - 12'h080});
            check("wr_tap_di", tap_Di, d);
        end
        cnt0 = tap_en_count;
        if (exp_tap) m_taps[idx] = d;
        if (a == 12'h010) m_len = d;
        if (exp_start) begin
            m_idle = 0;
            m_done = 0;
        end
        @(negedge clk); #1;
        check("wr_gap_ready", {30'b0, awready, wready}, 32'd0);
        check("wr_start_pulse", {31'b0, ap_start_o}, {31'b0, exp_start});
        check("wr_data_length", data_length_o, m_len);
        check("wr_tap_en_count", 32'(tap_en_count - cnt0), {31'b0, exp_tap});
        awvalid = 0; wvalid = 0;
        @(negedge clk); #1;
        check("wr_start_ended", {31'b0, ap_start_o}, 32'd0);
        $display("write addr=0x%03h data=0x%08h tap=%0d start=%0d", a, d, exp_tap, exp_start);
    endtask

    task automatic axil_read(input logic [11:0] a, input bit done_in_fetch, input bit rst_in_resp);
        int idx, n, hold;
        bit exp_tap;
        logic [31:0] exp;
        idx     = tap_index(a);
        exp_tap = (idx >= 0) && m_idle;
        if (a == 12'h000)      exp = {29'b0, m_idle, m_done, 1'b0};
        else if (a == 12'h010) exp = m_len;
        else if (exp_tap)      exp = m_taps[idx];
        else                   exp = 32'd0;
        @(negedge clk);
        arvalid = 1; araddr = a;
        #1;
        n = 0;
        while (!arready && n < 8) begin
            @(negedge clk); #1; n++;
        end
        check("rd_arready", {31'b0, arready}, 32'd1);
        check("rd_tap_en", {31'b0, tap_EN}, {31'b0, exp_tap});
        if (exp_tap) begin
            check("rd_tap_we", {28'b0, tap_WE}, 32'd0);
            check("rd_tap_a", {20'b0, tap_A}, {20'b0, a - 12'h080});
        end
        @(negedge clk);
        arvalid = 0;
        #1;
        if (done_in_fetch) engine_done_i = 1;
        check("rd_fetch_rvalid", {31'b0, rvalid}, 32'd0);
        if (a == 12'h000) m_done = 0;
        if (done_in_fetch) begin
            m_done = 1;
            m_idle = 1;
        end
        @(negedge clk);
        engine_done_i = 0;
        #1;
        check("rd_rvalid", {31'b0, rvalid}, 32'd1);
        check("rd_data", rdata, exp);
        if (rst_in_resp) begin
            rst = 1;
            #1;
            check("rst_rvalid_drop", {31'b0, rvalid}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
            model_reset();
            @(negedge clk);
            rst = 0;
            $display("read  addr=0x%03h data=0x%08h (reset in response)", a, exp);
            return;
        end
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check("rd_hold_rvalid", {31'b0, rvalid}, 32'd1);
            check("rd_hold_data", rdata, exp);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        #1;
        check("rd_release", {31'b0, rvalid}, 32'd0);
        $display("read  addr=0x%03h data=0x%08h hold=%0d", a, exp, hold);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        engine_done_i = 1;
        @(negedge clk);
        engine_done_i = 0;
        m_done = 1;
        m_idle = 1;
        $display("engine done pulse");
    endtask

    initial begin
        int coef [NUM_TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        logic [31:0] v;
        int idx;
        rst = 1;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; engine_done_i = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        model_reset();
        for (int i = 0; i < NUM_TAPS; i++) m_taps[i] = 32'd0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("reset_ready", {29'b0, awready, wready, arready}, 32'd0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_start", {31'b0, ap_start_o}, 32'd0);
        check("reset_data_length", data_length_o, 32'd0);
        check("reset_tap_en", {27'b0, tap_EN, tap_WE}, 32'd0);

        axil_read(12'h000, 0, 0);
        axil_write(12'h010, 32'd600);
        axil_read(12'h010, 0, 0);

        // Half a write request must never be accepted
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            awvalid = (k == 0); wvalid = (k == 1); awaddr = 12'h080; wdata = 32'h5;
            for (int c = 0; c < 2; c++) begin
                #1;
                check("half_req_ready", {30'b0, awready, wready}, 32'd0);
                check("half_req_tap_en", {31'b0, tap_EN}, 32'd0);
                @(negedge clk);
            end
            awvalid = 0; wvalid = 0;
        end

        for (int i = 0; i < NUM_TAPS; i++) axil_write(12'(12'h080 + 4 * i), 32'(coef[i]));
        for (int i = 0; i < NUM_TAPS; i++) axil_read(12'(12'h080 + 4 * i), 0, 0);
        axil_write(12'h0AC, 32'hDEADBEEF);
        axil_read(12'h0AC, 0, 0);

        for (int r = 0; r < 5; r++) begin
            axil_write(12'h010, $urandom);
            idx = $urandom_range(0, NUM_TAPS - 1);
            axil_write(12'(12'h080 + 4 * idx), $urandom);
            axil_read(12'(12'h080 + 4 * idx), 0, 0);
            v = 32'h100 + 4 * $urandom_range(0, 200);
            axil_write(v[11:0], $urandom);
            axil_read(v[11:0], 0, 0);
            axil_read(12'h010, 0, 0);
        end

        axil_write(12'h000, 32'd1);
        axil_read(12'h000, 0, 0);
        axil_write(12'h084, 32'd99);
        axil_read(12'h084, 0, 0);
        axil_write(12'h000, 32'd1);

        pulse_done();
        axil_read(12'h000, 0, 0);
        axil_read(12'h000, 0, 0);
        axil_read(12'h084, 0, 0);

        axil_write(12'h000, 32'd1);
        axil_read(12'h000, 1, 0);
        axil_read(12'h000, 0, 0);
        axil_read(12'h000, 0, 0);

        axil_write(12'h010, 32'd1234);
        axil_read(12'h010, 0, 1);
        #1;
        check("post_reset_data_length", data_length_o, 32'd0);
        axil_read(12'h010, 0, 0);
        axil_read(12'h000, 0, 0);
        axil_read(12'h094, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fir_axil_slave.md
Name: fir_axil_slave

Overview:
AXI-Lite responder (slave) for the FIR accelerator configuration space. It sits at the far end of the Wishbone-to-AXI-Lite bridge. It accepts the bridge's single-beat writes and reads. It owns the ap_ctrl and data_length registers and forwards tap-coefficient accesses to an external single-port tap BRAM. It also generates the ap_start pulse for the FIR engine and tracks the engine's done/idle status.

Parameters:
ADDR_W, 12, AXI-Lite address width (awaddr/araddr/tap_A)
DATA_W, 32, data width of registers, wdata/rdata and tap BRAM
NUM_TAPS, 11, number of valid tap words at 0x080 + 4*i

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  asynchronous active-high reset
awvalid  input  1  write address valid
awready  output  1  write address ready
awaddr  input  ADDR_W  write byte address
wvalid  input  1  write data valid
wready  output  1  write data ready
wdata  input  DATA_W  write data
arvalid  input  1  read address valid
arready  output  1  read address ready
araddr  input  ADDR_W  read byte address
rvalid  output  1  read data valid
rready  input  1  read data ready
rdata  output  DATA_W  read data
ap_start_o  output  1  one-cycle start pulse to FIR engine
engine_done_i  input  1  one-cycle done pulse from FIR engine
data_length_o  output  DATA_W  current data_length register
tap_EN  output  1  tap BRAM enable
tap_WE  output  4  tap BRAM byte write enables
tap_A  output  ADDR_W  tap BRAM byte address (awaddr/araddr minus 0x080)
tap_Di  output  DATA_W  tap BRAM write data
tap_Do  input  DATA_W  tap BRAM read data, valid 1 cycle after tap_EN with tap_WE=0

Behaviour:
- Clock wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values: awready=wready=arready=rvalid=0, rdata=0, ap_start_o=0, data_length=0, ap_done=0, ap_idle=1, tap_EN=0, tap_WE=0, FSMs in IDLE.
- Register map:
  - 0x000 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle, other bits read 0.
  - 0x010 data_length: RW.
  - 0x080..0x080+4*NUM_TAPS-4: taps.
  - All other addresses: writes dropped, reads return 0. The handshake still completes.
- Write path:
  - awready and wready are asserted together, for exactly one cycle, in the cycle where awvalid & wvalid & read FSM IDLE & write FSM W_IDLE.
  - Next cycle is W_GAP (both low). Then return to W_IDLE. So a held request is accepted only once per Wishbone cycle.
  - No B channel.
  - awvalid without wvalid, or the reverse: nothing is accepted and nothing is asserted.
- ap_ctrl write:
  - If wdata[0]=1 and ap_idle=1: ap_start_o=1 for the next cycle only, ap_idle<=0, ap_done<=0.
  - If ap_idle=0: the write is acked and ignored.
  - Bits 1 and 2 are not writable.
- Tap write in the accept cycle:
  - tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x080, tap_Di=wdata.
  - Blocked (tap_WE=0, no tap_EN) while ap_idle=0.
- engine_done_i: ap_done<=1, ap_idle<=1. If it coincides with an ap_ctrl read, the set wins: ap_done stays 1.
- Read FSM states R_IDLE, R_FETCH, R_RESP:
  - R_IDLE:
    - arready=1 combinationally when arvalid & write FSM W_IDLE & !(awvalid&wvalid). Write has priority.
    - On the handshake, latch araddr. For a tap address, drive tap_EN=1, tap_WE=0, tap_A. Go to R_FETCH.
  - R_FETCH:
    - Register rdata from the selected source (tap_Do, ap_ctrl, data_length, or 0). Set rvalid=1. Go to R_RESP.
    - Reading ap_ctrl captures the current value, then clears ap_done. ap_idle is unchanged.
    - Tap read while ap_idle=0 returns 0 and does not touch the BRAM.
  - R_RESP:
    - rvalid and rdata are held stable until rready.
    - On rvalid & rready: rvalid<=0, go to R_IDLE.
  - Latency: arready handshake to rvalid = 2 cycles.
- data_length_o is the register value directly; it updates the cycle after the write.
- Reset mid-transaction: all FSMs return to IDLE and rvalid drops immediately. A pending tap write that was not yet issued is lost.

Test Plan:
- Reset, then read 0x000 -> arready in cycle 0, rvalid 2 cycles later, rdata=0x00000004; rvalid held until rready.
- Write 0x010 data=600, read 0x010 -> data_length_o=600 one cycle after the write ack; rdata=600; awready/wready high exactly 1 cycle.
- Write taps 0x080..0x0A8 with 0,-10,-9,23,56,63,56,23,-9,-10,0, then read them back -> tap_WE=F, tap_A=0x00..0x28; reads return the identical values. Write and read at 0x0AC -> no tap_EN; read returns 0.
- Write 0x000 data=1 -> ap_start_o high 1 cycle; ap_ctrl read =0x0. A tap write while busy -> acked, tap_EN stays 0. A second start write -> no pulse.
- Pulse engine_done_i, then read 0x000 twice -> first returns 0x6, second 0x4. With engine_done_i coincident with the ap_ctrl read -> the next read still returns 0x6.
- Assert wb_rst_i while in R_RESP -> rvalid=0 immediately; a subsequent read completes normally.
